and_coinc_stretch: RTL and testbench
====================================

# and_coinc_stretch

Parametrised multi-channel AND coincidence unit for the trigger path. Each channel ANDs a maskable group of inputs, detects the rising edge of the coincidence and emits a registered, programmable-width, non-retriggerable pulse on a true/complement output pair. It also keeps a saturating per-channel hit count. It replaces fixed quad 2-input AND parts where synchronous pulse shaping and counting are needed.

## Interface
Parameters:
- CHANNELS, 4, number of independent AND channels
- INPUTS, 2, inputs per channel (>=1)
- STRETCH_W, 8, width of pulse-length field
- COUNT_W, 16, width of each hit counter

Ports:
- CLK  in  1  single system clock; all state on rising edge
- RESET_  in  1  asynchronous active-low reset
- IN  in  CHANNELS*INPUTS  channel c input i at bit c*INPUTS+i
- MASK  in  CHANNELS*INPUTS  1 = input participates; same bit order as IN
- STRETCH  in  STRETCH_W  output pulse length minus one, in cycles
- CLR_COUNT  in  1  synchronous clear of all hit counters
- OUT  out  CHANNELS  registered coincidence pulse
- OUT_  out  CHANNELS  exact complement of OUT, same register timing
- COUNT  out  CHANNELS*COUNT_W  channel c hit count at bits [c*COUNT_W +: COUNT_W]

## Operation
- Input stage: IN is registered once into IN_Q.
- Coincidence per channel: coinc[c] = AND over i of (IN_Q[c,i] | ~MASK[c,i]). If all MASK bits of a channel are 0, coinc[c] = 0 (channel disabled).
- Edge detect: coinc_prev[c] is registered every cycle. A rising edge is coinc[c] & ~coinc_prev[c].
- Per-channel FSM with states IDLE and ACTIVE, plus a STRETCH_W down-counter.
  - IDLE, rising edge: load counter with STRETCH, go to ACTIVE, set OUT = 1, increment count.
  - ACTIVE, counter != 0: decrement counter. Rising edges are ignored (non-retriggerable) and are not counted.
  - ACTIVE, counter == 0: go to IDLE, set OUT = 0. An edge in this same cycle is lost.
- Pulse width is exactly STRETCH+1 cycles. STRETCH is sampled only at trigger; changes mid-pulse do not affect the current pulse.
- A level held high produces one pulse only. Re-arming needs coinc to go low, then high again.
- Counter: saturates at 2^COUNT_W-1. CLR_COUNT zeroes all counters; clear wins over a simultaneous increment, giving 0.
- MASK changes take effect on the next coinc evaluation and may themselves create a rising edge.
- Channels are fully independent.

## Timing
- Reset (RESET_ low, async) sets:
  - OUT = 0, OUT_ = all ones, COUNT = 0
  - all FSMs to IDLE, counters 0, IN_Q = 0
  - coinc_prev = all ones, so a coincidence already true at reset release does not fire.
- Reset asserted mid-pulse: OUT drops immediately (async). No pulse resumes after release.
- Latency: an IN change set up before edge k is in IN_Q at edge k, and OUT rises at edge k+1 (2 edges). COUNT updates at the same edge as OUT.
- OUT falls at edge k+1+STRETCH+1.
- Minimum gap between accepted triggers: STRETCH+2 cycles. The earliest re-arm edge is evaluated in the first IDLE cycle.
- Inputs narrower than one clock may be missed; no capture latch is provided.

## Configuration
- AND_COINC_SYNC_EN defined: IN passes through a 2-flop synchroniser ahead of IN_Q. The input stage becomes 3 flops and latency is 4 edges. The synchroniser flops reset to 0. Use this for inputs asynchronous to CLK.
- AND_COINC_SYNC_EN undefined: a single input register, latency 2 edges. IN must be synchronous to CLK.

## Test plan
- Reset release with IN = all ones and MASK = all ones -> no pulse. Drop channel 0 inputs low for 1 cycle, then high -> OUT[0] high for STRETCH+1 = 4 cycles (STRETCH=3), 2 edges after the input rise; COUNT[0] = 1; OUT_[0] is always ~OUT[0].
- Channel 1 with MASK = 2'b01 and IN[1,1] = 0: toggle IN[1,0] -> pulses fire. Set MASK = 2'b00 -> no pulses.
- STRETCH=5, second rising edge 3 cycles after the first -> a single 6-cycle pulse and COUNT = 1. An edge arriving exactly in the last ACTIVE cycle is also ignored. An edge on the first IDLE cycle fires a new pulse.
- STRETCH=0 with an input toggling every 2 cycles -> one 1-cycle pulse per rise; COUNT tracks every rise.
- COUNT_W=4: 17 triggers -> COUNT saturates at 15. CLR_COUNT coincident with a trigger -> COUNT = 0 while OUT still pulses.
- RESET_ asserted mid-pulse, between clock edges -> OUT falls immediately, COUNT = 0; with inputs held high after release -> no new pulse.

Source files
------------

// File: rtl/and_coinc_stretch_if.sv
// Signal bundle for and_coinc_stretch: channel inputs, masks, pulse length and
// count clear towards the unit; shaped pulses and hit counts back from it.
interface and_coinc_stretch_if #(
    parameter int CHANNELS  = 4,
    parameter int INPUTS    = 2,
    parameter int STRETCH_W = 8,
    parameter int COUNT_W   = 16
);
    logic [CHANNELS*INPUTS-1:0]  in;
    logic [CHANNELS*INPUTS-1:0]  mask;
    logic [STRETCH_W-1:0]        stretch;
    logic                        clr_count;
    logic [CHANNELS-1:0]         out;
    logic [CHANNELS-1:0]         out_;
    logic [CHANNELS*COUNT_W-1:0] count;

    modport master (
        output in, mask, stretch, clr_count,
        input  out, out_, count
    );

    modport slave (
        input  in, mask, stretch, clr_count,
        output out, out_, count
    );
endinterface

// File: rtl/and_coinc_stretch.sv
// Multi-channel AND coincidence with rising-edge trigger, non-retriggerable pulse
// stretcher and saturating hit counters. AND_COINC_SYNC_EN adds a 2-flop input synchroniser.
module and_coinc_stretch #(
    parameter int CHANNELS  = 4,
    parameter int INPUTS    = 2,
    parameter int STRETCH_W = 8,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    and_coinc_stretch_if.slave bus
);
    localparam int NB = CHANNELS * INPUTS;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic [NB-1:0]        in_q_r;
    logic                 primed_s;
    logic [CHANNELS-1:0]  coinc_s;
    logic [CHANNELS-1:0]  coinc_prev_r;
    logic [CHANNELS-1:0]  rise_s;
    logic [CHANNELS-1:0]  hit_s;
    state_t               state_r   [CHANNELS];
    state_t               state_nxt [CHANNELS];
    logic [STRETCH_W-1:0] cnt_r     [CHANNELS];
    logic [STRETCH_W-1:0] cnt_nxt   [CHANNELS];
    logic [COUNT_W-1:0]   count_r   [CHANNELS];
    logic [COUNT_W-1:0]   count_nxt [CHANNELS];
    logic [CHANNELS-1:0]  out_r;
    logic [CHANNELS-1:0]  out_n_r;
    logic [CHANNELS-1:0]  out_nxt;

`ifdef AND_COINC_SYNC_EN
    logic [NB-1:0] sync1_r;
    logic [NB-1:0] sync2_r;
    logic [2:0]    fill_r;

    // Two-flop synchroniser then the input register; fill_r marks when IN_Q holds real data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {NB{1'b0}};
            sync2_r <= {NB{1'b0}};
            in_q_r  <= {NB{1'b0}};
            fill_r  <= 3'b000;
        end else begin
            sync1_r <= bus.in;
            sync2_r <= sync1_r;
            in_q_r  <= sync2_r;
            fill_r  <= {fill_r[1:0], 1'b1};
        end
    end

    assign primed_s = fill_r[2];
`else
    logic fill_r;

    // Single input register; fill_r marks when IN_Q holds real data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q_r <= {NB{1'b0}};
            fill_r <= 1'b0;
        end else begin
            in_q_r <= bus.in;
            fill_r <= 1'b1;
        end
    end

    assign primed_s = fill_r;
`endif

    // Masked AND per channel; a channel with no enabled inputs never coincides
    always_comb begin
        coinc_s = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            coinc_s[c] = (|bus.mask[c*INPUTS +: INPUTS]) &
                         (&(in_q_r[c*INPUTS +: INPUTS] | ~bus.mask[c*INPUTS +: INPUTS]));
        end
    end

    // Previous coincidence is held high until the input pipeline has filled after reset,
    // so a coincidence already present at release is not seen as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coinc_prev_r <= {CHANNELS{1'b1}};
        end else if (primed_s) begin
            coinc_prev_r <= coinc_s;
        end else begin
            coinc_prev_r <= {CHANNELS{1'b1}};
        end
    end

    assign rise_s = coinc_s & ~coinc_prev_r;

    // Per-channel stretcher FSM and saturating counter next-state
    always_comb begin
        hit_s   = {CHANNELS{1'b0}};
        out_nxt = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            state_nxt[c] = state_r[c];
            cnt_nxt[c]   = cnt_r[c];
            count_nxt[c] = count_r[c];
            case (state_r[c])
                IDLE: begin
                    if (rise_s[c]) begin
                        state_nxt[c] = ACTIVE;
                        cnt_nxt[c]   = bus.stretch;
                        out_nxt[c]   = 1'b1;
                        hit_s[c]     = 1'b1;
                    end else begin
                        out_nxt[c]   = 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cnt_r[c] != {STRETCH_W{1'b0}}) begin
                        cnt_nxt[c]   = cnt_r[c] - STRETCH_W'(1'b1);
                        out_nxt[c]   = 1'b1;
                    end else begin
                        state_nxt[c] = IDLE;
                        out_nxt[c]   = 1'b0;
                    end
                end
                default: begin
                    state_nxt[c] = IDLE;
                    cnt_nxt[c]   = {STRETCH_W{1'b0}};
                    out_nxt[c]   = 1'b0;
                end
            endcase
            if (bus.clr_count) begin
                count_nxt[c] = {COUNT_W{1'b0}};
            end else if (hit_s[c] && (count_r[c] != {COUNT_W{1'b1}})) begin
                count_nxt[c] = count_r[c] + COUNT_W'(1'b1);
            end else begin
                count_nxt[c] = count_r[c];
            end
        end
    end

    // Channel state, pulse outputs and hit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= {CHANNELS{1'b0}};
            out_n_r <= {CHANNELS{1'b1}};
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c] <= IDLE;
                cnt_r[c]   <= {STRETCH_W{1'b0}};
                count_r[c] <= {COUNT_W{1'b0}};
            end
        end else begin
            out_r   <= out_nxt;
            out_n_r <= ~out_nxt;
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c] <= state_nxt[c];
                cnt_r[c]   <= cnt_nxt[c];
                count_r[c] <= count_nxt[c];
            end
        end
    end

    // Pack counters onto the output bus
    always_comb begin
        bus.count = {(CHANNELS*COUNT_W){1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            bus.count[c*COUNT_W +: COUNT_W] = count_r[c];
        end
    end

    assign bus.out  = out_r;
    assign bus.out_ = out_n_r;
endmodule

// File: tb/tb_and_coinc_stretch.sv
// Directed bench for and_coinc_stretch (4 channels x 2 inputs, 4-bit counters):
// each step drives inputs, advances the clock and compares against hand-derived values.
module tb_and_coinc_stretch;
    localparam int CH = 4;
    localparam int IN = 2;
    localparam int SW = 8;
    localparam int CW = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    and_coinc_stretch_if #(.CHANNELS(CH), .INPUTS(IN), .STRETCH_W(SW), .COUNT_W(CW)) bus ();

    and_coinc_stretch #(.CHANNELS(CH), .INPUTS(IN), .STRETCH_W(SW), .COUNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in        = 8'hFF;
        bus.mask      = 8'hFF;
        bus.stretch   = 8'd3;
        bus.clr_count = 1'b0;
        tick(2);
        check("rst_out",   {28'd0, bus.out},  32'h0);
        check("rst_out_n", {28'd0, bus.out_}, 32'hF);
        check("rst_count", {16'd0, bus.count}, 32'h0);

        // Release with every coincidence already true: nothing may fire
        rst_n = 1'b1;
        tick(4);
        check("release_no_pulse", {28'd0, bus.out}, 32'h0);
        check("release_count",    {16'd0, bus.count}, 32'h0);

        // Channel 0: drop for one cycle then rise; STRETCH=3 -> 4-cycle pulse 2 edges later
        bus.in[1:0] = 2'b00;
        tick(1);
        bus.in[1:0] = 2'b11;
        tick(1);
        check("ch0_latency", {31'd0, bus.out[0]}, 32'd0);
        tick(1);
        check("ch0_rise",   {28'd0, bus.out},  32'h1);
        check("ch0_rise_n", {28'd0, bus.out_}, 32'hE);
        check("ch0_count",  {28'd0, bus.count[3:0]}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("ch0_hold", {31'd0, bus.out[0]}, 32'd1);
        end
        tick(1);
        check("ch0_fall",   {28'd0, bus.out},  32'h0);
        check("ch0_fall_n", {28'd0, bus.out_}, 32'hF);

        // Channel 1: only input 0 enabled, input 1 held low
        bus.mask[3:2] = 2'b01;
        bus.in[3:2]   = 2'b00;
        tick(2);
        bus.in[2] = 1'b1;
        tick(2);
        check("ch1_pulse_a", {31'd0, bus.out[1]}, 32'd1);
        check("ch1_count_a", {28'd0, bus.count[7:4]}, 32'd1);
        tick(4);
        check("ch1_end_a", {31'd0, bus.out[1]}, 32'd0);
        bus.in[2] = 1'b0;
        tick(2);
        bus.in[2] = 1'b1;
        tick(2);
        check("ch1_pulse_b", {31'd0, bus.out[1]}, 32'd1);
        check("ch1_count_b", {28'd0, bus.count[7:4]}, 32'd2);
        tick(4);
        bus.mask[3:2] = 2'b00;
        bus.in[2]     = 1'b0;
        tick(2);
        bus.in[2] = 1'b1;
        tick(2);
        check("ch1_disabled_a", {31'd0, bus.out[1]}, 32'd0);
        tick(2);
        check("ch1_disabled_b", {31'd0, bus.out[1]}, 32'd0);
        check("ch1_count_held", {28'd0, bus.count[7:4]}, 32'd2);

        // Channel 2, STRETCH=5: retrigger inside the pulse and in its last cycle are ignored
        bus.in[5:4] = 2'b00;
        tick(2);
        bus.stretch = 8'd5;
        bus.in[5:4] = 2'b11;
        tick(2);
        check("ch2_rise", {31'd0, bus.out[2]}, 32'd1);
        bus.in[5:4] = 2'b00;
        tick(1);
        bus.in[5:4] = 2'b11;
        tick(2);
        check("ch2_retrig_out",   {31'd0, bus.out[2]}, 32'd1);
        check("ch2_retrig_count", {28'd0, bus.count[11:8]}, 32'd1);
        bus.in[5:4] = 2'b00;
        tick(1);
        bus.in[5:4] = 2'b11;
        tick(1);
        check("ch2_last_active", {31'd0, bus.out[2]}, 32'd1);
        tick(1);
        check("ch2_fall_6", {31'd0, bus.out[2]}, 32'd0);
        tick(1);
        check("ch2_lost_edge", {31'd0, bus.out[2]}, 32'd0);
        check("ch2_lost_count", {28'd0, bus.count[11:8]}, 32'd1);

        // Channel 2: an edge evaluated in the first IDLE cycle fires again
        bus.in[5:4] = 2'b00;
        tick(2);
        bus.in[5:4] = 2'b11;
        tick(2);
        check("ch2_second", {28'd0, bus.count[11:8]}, 32'd2);
        tick(4);
        bus.in[5:4] = 2'b00;
        tick(1);
        bus.in[5:4] = 2'b11;
        tick(1);
        check("ch2_idle_gap", {31'd0, bus.out[2]}, 32'd0);
        tick(1);
        check("ch2_first_idle", {31'd0, bus.out[2]}, 32'd1);
        check("ch2_first_idle_cnt", {28'd0, bus.count[11:8]}, 32'd3);
        tick(5);
        check("ch2_width_hold", {31'd0, bus.out[2]}, 32'd1);
        tick(1);
        check("ch2_width_fall", {31'd0, bus.out[2]}, 32'd0);

        // Channel 3, STRETCH=0: one 1-cycle pulse per rise
        bus.stretch = 8'd0;
        bus.in[7:6] = 2'b00;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            bus.in[7:6] = 2'b11;
            tick(2);
            check("ch3_s0_high", {31'd0, bus.out[3]}, 32'd1);
            check("ch3_s0_count", {28'd0, bus.count[15:12]}, i + 1);
            bus.in[7:6] = 2'b00;
            tick(1);
            check("ch3_s0_low", {31'd0, bus.out[3]}, 32'd0);
            tick(1);
        end

        // Clear all counters, then saturate channel 0 at 15
        bus.clr_count = 1'b1;
        tick(1);
        bus.clr_count = 1'b0;
        check("clr_all", {16'd0, bus.count}, 32'h0);
        bus.in[1:0] = 2'b00;
        tick(2);
        for (int i = 0; i < 17; i++) begin
            bus.in[1:0] = 2'b11;
            tick(2);
            if (i == 14) check("sat_reach", {28'd0, bus.count[3:0]}, 32'd15);
            bus.in[1:0] = 2'b00;
            tick(2);
        end
        check("sat_hold", {28'd0, bus.count[3:0]}, 32'd15);

        // Clear coincident with a trigger: pulse still fires, count is 0
        bus.in[1:0] = 2'b11;
        tick(1);
        bus.clr_count = 1'b1;
        tick(1);
        bus.clr_count = 1'b0;
        check("clr_trig_out",   {31'd0, bus.out[0]}, 32'd1);
        check("clr_trig_count", {28'd0, bus.count[3:0]}, 32'd0);
        tick(1);
        check("clr_trig_after", {28'd0, bus.count[3:0]}, 32'd0);

        // Reset asserted between edges in the middle of a STRETCH=3 pulse
        bus.stretch = 8'd3;
        bus.in[1:0] = 2'b00;
        tick(2);
        bus.in[1:0] = 2'b11;
        tick(2);
        check("mid_pulse_up", {31'd0, bus.out[0]}, 32'd1);
        tick(1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out",   {28'd0, bus.out},  32'h0);
        check("mid_rst_out_n", {28'd0, bus.out_}, 32'hF);
        check("mid_rst_count", {16'd0, bus.count}, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("post_rst_quiet", {28'd0, bus.out}, 32'h0);
        end
        check("post_rst_count", {16'd0, bus.count}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
